// File: rtl/ram_pkg.sv
// Shared widths, FSM state and command bundle
// for the RAM request sequencer.
package ram_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } req_state_e;

  typedef struct packed {
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
  } ram_cmd_t;

endpackage

// File: rtl/ram_req_fifo.sv
// Command FIFO for the RAM request sequencer.
// Power-of-2 depth; pointers wrap naturally.
module ram_req_fifo
  import ram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  ram_cmd_t din,
  input  logic     pop,
  output ram_cmd_t dout,
  output logic     full,
  output logic     empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  ram_cmd_t        mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_req_ctrl.sv
// Host-to-RAM request sequencer: FIFO-buffered
// commands, one outstanding, in-order responses.
module ram_req_ctrl #(
  parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr_rd,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_din,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr_rd,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  ram_en,
  output logic                  ram_valid,
  output logic                  ram_wr_rd,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  ram_ready,
  input  logic                  ram_error,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT-1);

  ram_pkg::ram_cmd_t   push_cmd;
  ram_pkg::ram_cmd_t   head;
  ram_pkg::ram_cmd_t   cmd;
  ram_pkg::req_state_e state;
  logic [TW-1:0]       timer;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  // No bypass: a full FIFO refuses even while popping.
  assign req_ready = !full && !rst;
  assign push      = req_valid && req_ready;
  assign pop       = (state == ram_pkg::IDLE) && !empty;

  assign push_cmd.wr_rd = req_wr_rd;
  assign push_cmd.addr  = req_addr;
  assign push_cmd.din   = req_din;

  ram_req_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (push_cmd),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(fifo_count)
  );

  assign ram_en    = (state == ram_pkg::ISSUE);
  assign ram_valid = (state == ram_pkg::ISSUE);
  assign rsp_valid = (state == ram_pkg::RESP);
  assign ram_wr_rd = cmd.wr_rd;
  assign ram_addr  = cmd.addr;
  assign ram_din   = cmd.din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ram_pkg::IDLE;
      cmd         <= '0;
      timer       <= '0;
      rsp_wr_rd   <= 1'b0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        ram_pkg::IDLE: begin
          if (!empty) begin
            cmd   <= head;
            timer <= '0;
            state <= ram_pkg::ISSUE;
          end
        end
        ram_pkg::ISSUE: begin
          // ram_ready beats the timeout in the final cycle
          if (ram_ready) begin
            rsp_wr_rd   <= cmd.wr_rd;
            rsp_data    <= cmd.wr_rd ? '0 : ram_dout;
            rsp_error   <= ram_error;
            rsp_timeout <= 1'b0;
            state       <= ram_pkg::RESP;
          end else if (timer == TLAST) begin
            rsp_wr_rd   <= cmd.wr_rd;
            rsp_data    <= '0;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= ram_pkg::RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ram_pkg::RESP: begin
          if (rsp_ready) state <= ram_pkg::IDLE;
        end
        default: state <= ram_pkg::IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed self-checking bench for ram_req_ctrl
// with a small behavioural RAM behind it.
module tb_ram_req_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr_rd;
  logic [7:0]  req_addr;
  logic [31:0] req_din;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr_rd;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        ram_en;
  logic        ram_valid;
  logic        ram_wr_rd;
  logic [7:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_ready;
  logic        ram_error;
  logic [2:0]  fifo_count;

  logic [31:0] mem [256];
  int vectors = 0;
  int errs = 0;

  ram_req_ctrl #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .FIFO_DEPTH(4),
    .TIMEOUT   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr_rd  (req_wr_rd),
    .req_addr   (req_addr),
    .req_din    (req_din),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_wr_rd  (rsp_wr_rd),
    .rsp_data   (rsp_data),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .ram_en     (ram_en),
    .ram_valid  (ram_valid),
    .ram_wr_rd  (ram_wr_rd),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .ram_ready  (ram_ready),
    .ram_error  (ram_error),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [7:0] a,
                      input logic [31:0] d);
    req_valid = 1'b1;
    req_wr_rd = wr;
    req_addr  = a;
    req_din   = d;
    chk("push_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_ram_valid();
    int n = 0;
    while (ram_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ram_valid_wait", ram_valid, 1);
  endtask

  task automatic run_cmd(input logic wr, input logic [7:0] a,
                         input int lat, input logic err,
                         input logic [31:0] exp_data,
                         input logic exp_err);
    wait_ram_valid();
    chk("ram_en", ram_en, 1);
    chk("ram_wr_rd", ram_wr_rd, wr);
    chk("ram_addr", ram_addr, a);
    repeat (lat) @(negedge clk);
    ram_ready = 1'b1;
    ram_error = err;
    if (ram_wr_rd) begin
      mem[ram_addr] = ram_din;
      ram_dout = 32'hDEAD_BEEF;
    end else begin
      ram_dout = mem[ram_addr];
    end
    @(negedge clk);
    ram_ready = 1'b0;
    ram_error = 1'b0;
    ram_dout  = '0;
    chk("rsp_valid", rsp_valid, 1);
    chk("ram_valid_in_resp", ram_valid, 0);
    chk("rsp_wr_rd", rsp_wr_rd, wr);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_error", rsp_error, exp_err);
    chk("rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
  endtask

  initial begin
    int n;
    logic seen;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 5; i++) mem[8'h10 + i] = 32'h1000_0000 + i;
    mem[8'h20] = 32'h2020_2020;
    mem[8'hFF] = 32'hFFFF_0000;
    rst = 1'b1;
    req_valid = 1'b0;
    req_wr_rd = 1'b0;
    req_addr  = '0;
    req_din   = '0;
    rsp_ready = 1'b0;
    ram_dout  = '0;
    ram_ready = 1'b0;
    ram_error = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ram_valid", ram_valid, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_ram_addr", ram_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);

    // write then read back
    push(1'b1, 8'h05, 32'hA5A5_A5A5);
    run_cmd(1'b1, 8'h05, 1, 1'b0, 32'h0, 1'b0);
    chk("ram_din_written", mem[8'h05], 32'hA5A5_A5A5);
    push(1'b0, 8'h05, 32'h0);
    run_cmd(1'b0, 8'h05, 1, 1'b0, 32'hA5A5_A5A5, 1'b0);

    // fill: one in ISSUE, four buffered, sixth refused
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_wr_rd = 1'b0;
      req_addr  = 8'h10 + 8'(i);
      req_din   = '0;
      chk("fill_req_ready", req_ready, (i < 5) ? 1 : 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("fill_count", fifo_count, 4);
    chk("fill_ready_low", req_ready, 0);
    for (int i = 0; i < 5; i++)
      run_cmd(1'b0, 8'h10 + 8'(i), 0, 1'b0,
              32'h1000_0000 + i, 1'b0);
    chk("drain_count", fifo_count, 0);

    // timeout: RAM never answers
    push(1'b0, 8'h20, 32'h0);
    wait_ram_valid();
    n = 0;
    while (ram_valid === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_cycles", n, 16);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_error", rsp_error, 1);
    chk("to_rsp_data", rsp_data, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    push(1'b0, 8'h05, 32'h0);
    run_cmd(1'b0, 8'h05, 1, 1'b0, 32'hA5A5_A5A5, 1'b0);

    // ready in the 16th ISSUE cycle still completes normally
    push(1'b0, 8'h10, 32'h0);
    run_cmd(1'b0, 8'h10, 15, 1'b0, 32'h1000_0000, 1'b0);

    // RAM error on a read
    push(1'b0, 8'hFF, 32'h0);
    run_cmd(1'b0, 8'hFF, 0, 1'b1, 32'hFFFF_0000, 1'b1);

    // reset while a command is in ISSUE
    push(1'b0, 8'h30, 32'h0);
    push(1'b0, 8'h31, 32'h0);
    push(1'b0, 8'h32, 32'h0);
    chk("pre_rst_ram_valid", ram_valid, 1);
    chk("pre_rst_count", fifo_count, 2);
    rst = 1'b1;
    #1;
    chk("async_ram_valid", ram_valid, 0);
    chk("async_count", fifo_count, 0);
    chk("async_req_ready", req_ready, 0);
    @(negedge clk);
    chk("rst_hold_req_ready", req_ready, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || ram_valid !== 1'b0) seen = 1'b1;
    end
    chk("post_rst_quiet", seen, 0);
    chk("post_rst_count", fifo_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
